apb_arbiter: RTL

Round-robin arbiter that shares one APB master port among NUM_REQ requesters, e.g. several sampler channels that each need to post 32-bit samples to the same APB slave. Each requester presents a simple request/done interface. The arbiter selects one requester, sequences the APB SETUP/ACCESS phases for it, and returns completion, read data and a timeout error. It sits between the sampler channels and the single APB slave port.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 43 ++++
 rtl/apb_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin arbiter: FSM state encoding and
// default parameter values used by apb_arbiter and its picker.
package apb_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req_i      - request vector, one bit per requester
//   last_ptr_i - index of the most recently served requester
//   win_oh_o   - one-hot winner (all zero when nothing requests)
//   win_idx_o  - binary index of the winner
//   valid_o    - at least one requester is asking
// The winner is the first requesting index strictly after last_ptr_i,
// wrapping, so the last served requester has the lowest priority.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_ptr_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    cand      = '0;
    // Scan from the farthest offset down to the nearest, so the candidate
    // closest after last_ptr_i is the one that sticks.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_ptr_i) + off) % NUM_REQ);
      if (req_i[cand]) begin
        win_idx_o       = cand;
        win_oh_o        = '0;
        win_oh_o[cand]  = 1'b1;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB master port among NUM_REQ requesters using round-robin
// arbitration and sequences the SETUP/ACCESS phases for the winner.
// Ports:
//   pclk, presetn           - clock, asynchronous active-low reset
//   req_i/req_addr_i/
//   req_wdata_i/req_write_i - per-requester request level and transfer fields
//   gnt_o                   - one-hot owner of the current transfer (0 in IDLE)
//   done_o, err_o           - one-cycle completion pulse; err_o = timeout abort
//   rdata_o                 - prdata passthrough, valid with done_o && !err_o
//   psel/penable/pwrite/
//   paddr/pwdata            - APB master outputs
//   pready, prdata          - APB slave responses
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  // Reset value makes requester 0 the first winner.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i      (req_i),
    .last_ptr_i (last_ptr_q),
    .win_oh_o   (pick_oh),
    .win_idx_o  (pick_idx),
    .valid_o    (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    psel       = 1'b0;
    penable    = 1'b0;
    done_o     = '0;
    err_o      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_oh;
          idx_d    = pick_idx;
          paddr_d  = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
          pwrite_d = req_write_i[pick_idx];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A pready in the final allowed cycle still completes normally.
        if (pready || (cnt_q == CNT_LAST)) begin
          done_o     = gnt_q;
          err_o      = !pready;
          last_ptr_d = idx_q;
          gnt_d      = '0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      last_ptr_q <= LAST_RST;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign rdata_o = prdata;

endmodule
